aes_inv_cipher_top: RTL

- AES-128 decryption datapath: the inverse-direction companion to the encrypt core, sharing key width, block width and the ld/done handshake style.
- An explicit key-load phase (kld) runs the forward key schedule once and caches all 11 round keys.
- Each ld then decrypts one 128-bit block, consuming the cached round keys in reverse order, one round per clock.
- Instantiates aes_key_expand_128 (forward schedule) and 16 aes_inv_sbox instances.

---
 rtl/aes_inv_cipher_top.sv | 326 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_inv_cipher_top.sv
// rtl/aes_inv_cipher_top.sv - AES-128 inverse cipher with cached round keys; optional busy via AES_DEC_BUSY_EN

// GF(2^8) multiplicative inverse (x^254, poly 0x11b); maps 0 to 0
module aes_gf_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gf_mul(input logic [7:0] p, input logic [7:0] q);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = p;
        for (int i = 0; i < 8; i++) begin
            if (q[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_pow254(input logic [7:0] x);
        logic [7:0] t;
        t = gf_mul(gf_mul(x, x), x);     // x^3
        t = gf_mul(gf_mul(t, t), x);     // x^7
        t = gf_mul(gf_mul(t, t), x);     // x^15
        t = gf_mul(gf_mul(t, t), x);     // x^31
        t = gf_mul(gf_mul(t, t), x);     // x^63
        t = gf_mul(gf_mul(t, t), x);     // x^127
        return gf_mul(t, t);             // x^254
    endfunction

    assign y = gf_pow254(a);

endmodule

// Forward S-box: field inverse followed by the affine transform
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);

    logic [7:0] inv_a;

    aes_gf_inv u_inv (.a(a), .y(inv_a));

    assign d = inv_a ^ {inv_a[6:0], inv_a[7]} ^ {inv_a[5:0], inv_a[7:6]}
             ^ {inv_a[4:0], inv_a[7:5]} ^ {inv_a[3:0], inv_a[7:4]} ^ 8'h63;

endmodule

// Inverse S-box: inverse affine transform followed by the field inverse
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);

    logic [7:0] pre;

    assign pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;

    aes_gf_inv u_inv (.a(pre), .y(d));

endmodule

// Forward AES-128 key schedule: round key r appears r cycles after the load edge
module aes_key_expand_128 (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [127:0] round_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] rot_w, sub_w;
    logic [7:0]  rcon;

    assign round_key = {w0, w1, w2, w3};
    assign rot_w     = {w3[23:0], w3[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sub
            aes_sbox u_sbox (.a(rot_w[8*g +: 8]), .d(sub_w[8*g +: 8]));
        end
    endgenerate

    assign n0 = w0 ^ sub_w ^ {rcon, 24'h000000};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    // Word registers and round constant; kld reloads the cipher key
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w0   <= '0;
            w1   <= '0;
            w2   <= '0;
            w3   <= '0;
            rcon <= '0;
        end else if (kld) begin
            {w0, w1, w2, w3} <= key;
            rcon             <= 8'h01;
        end else begin
            w0   <= n0;
            w1   <= n1;
            w2   <= n2;
            w3   <= n3;
            rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
        end
    end

endmodule

module aes_inv_cipher_top #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic         key_ready,
    input  logic         ld,
    input  logic [127:0] text_in,
`ifdef AES_DEC_BUSY_EN
    output logic         busy,
`endif
    output logic         done,
    output logic [127:0] text_out
);

    typedef enum logic [1:0] {KS_IDLE, KS_EXPAND, KS_FINISH} ks_t;
    typedef enum logic [1:0] {DS_IDLE, DS_INIT, DS_ROUND, DS_FINAL} ds_t;

    ks_t ks_state, ks_next;
    ds_t ds_state, ds_next;

    logic [3:0]   kcnt;
    logic [3:0]   rcnt;
    logic [127:0] expand_rk;
    logic [127:0] rk_cache [0:NR];
    logic [127:0] text_in_r;
    logic [127:0] state;
    logic [127:0] isr, isb, round_out, final_out;
    logic         ld_accept;

`ifdef AES_DEC_BUSY_EN
    assign ld_accept = ld && key_ready && !kld && !busy;
`else
    assign ld_accept = ld && key_ready && !kld;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [0:3];
        logic [7:0]   m9 [0:3];
        logic [7:0]   mb [0:3];
        logic [7:0]   md [0:3];
        logic [7:0]   me [0:3];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127-8*(4*c+r) -: 8];
                x2    = xt(a[r]);
                x4    = xt(x2);
                x8    = xt(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    aes_key_expand_128 u_expand (
        .clk       (clk),
        .rst       (rst),
        .kld       (kld),
        .key       (key),
        .round_key (expand_rk)
    );

    assign isr = inv_shift_rows(state);

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_isb
            aes_inv_sbox u_isbox (.a(isr[127-8*g -: 8]), .d(isb[127-8*g -: 8]));
        end
    endgenerate

    assign round_out = inv_mix_columns(isb ^ rk_cache[rcnt]);
    assign final_out = isb ^ rk_cache[0];

    // Key-schedule FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ks_state <= KS_IDLE;
        else      ks_state <= ks_next;
    end

    // Key-schedule next state: kld always (re)starts the expansion
    always_comb begin
        ks_next = ks_state;
        if (kld) begin
            ks_next = KS_EXPAND;
        end else begin
            case (ks_state)
                KS_EXPAND: if (kcnt == 4'(NR)) ks_next = KS_FINISH;
                KS_FINISH: ks_next = KS_IDLE;
                default:   ks_next = ks_state;
            endcase
        end
    end

    // Key counter and key_ready: ready one edge after the last cache write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kcnt      <= '0;
            key_ready <= 1'b0;
        end else if (kld) begin
            kcnt      <= '0;
            key_ready <= 1'b0;
        end else if (ks_state == KS_EXPAND) begin
            kcnt <= kcnt + 4'd1;
        end else if (ks_state == KS_FINISH) begin
            key_ready <= 1'b1;
        end
    end

    // Round-key cache, filled in schedule order; contents are not reset
    always_ff @(posedge clk) begin
        if (ks_state == KS_EXPAND && !kld) rk_cache[kcnt] <= expand_rk;
    end

    // Decrypt FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ds_state <= DS_IDLE;
        else      ds_state <= ds_next;
    end

    // Decrypt next state: kld aborts, an accepted ld restarts from capture
    always_comb begin
        ds_next = ds_state;
        if (kld) begin
            ds_next = DS_IDLE;
        end else if (ld_accept) begin
            ds_next = DS_INIT;
        end else begin
            case (ds_state)
                DS_INIT:  ds_next = DS_ROUND;
                DS_ROUND: if (rcnt == 4'd1) ds_next = DS_FINAL;
                DS_FINAL: ds_next = DS_IDLE;
                default:  ds_next = DS_IDLE;
            endcase
        end
    end

    // Decrypt datapath: capture, initial AddRoundKey, rounds NR-1..1, final round
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            text_in_r <= '0;
            state     <= '0;
            rcnt      <= '0;
            text_out  <= '0;
            done      <= 1'b0;
`ifdef AES_DEC_BUSY_EN
            busy      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (kld) begin
                rcnt <= '0;
`ifdef AES_DEC_BUSY_EN
                busy <= 1'b0;
`endif
            end else if (ld_accept) begin
                text_in_r <= text_in;
`ifdef AES_DEC_BUSY_EN
                busy      <= 1'b1;
`endif
            end else begin
                case (ds_state)
                    DS_INIT: begin
                        state <= text_in_r ^ rk_cache[NR];
                        rcnt  <= 4'(NR - 1);
                    end
                    DS_ROUND: begin
                        state <= round_out;
                        rcnt  <= rcnt - 4'd1;
                    end
                    DS_FINAL: begin
                        text_out <= final_out;
                        done     <= 1'b1;
`ifdef AES_DEC_BUSY_EN
                        busy     <= 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
